// File: rtl/commit_stage.sv
// Commit/writeback stage: arbitrates ALU/LD/CSR/FPU results onto one registered
// register-file write port and reports per-cycle committed thread-instruction counts.
module commit_stage #(
    parameter int CORE_ID     = 0,
    parameter int NUM_THREADS = 4,
    parameter int NUM_WARPS   = 4,
    parameter int NR_BITS     = 5,
    localparam int NW_BITS    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int CMTW       = $clog2(3*NUM_THREADS+1)
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [NW_BITS-1:0]       alu_wid,
    input  logic [31:0]              alu_pc,
    input  logic [NUM_THREADS-1:0]   alu_tmask,
    input  logic                     alu_wb,
    input  logic [NR_BITS-1:0]       alu_rd,
    input  logic [NUM_THREADS*32-1:0] alu_data,

    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [NW_BITS-1:0]       ld_wid,
    input  logic [31:0]              ld_pc,
    input  logic [NUM_THREADS-1:0]   ld_tmask,
    input  logic                     ld_wb,
    input  logic [NR_BITS-1:0]       ld_rd,
    input  logic [NUM_THREADS*32-1:0] ld_data,

    input  logic                     csr_valid,
    output logic                     csr_ready,
    input  logic [NW_BITS-1:0]       csr_wid,
    input  logic [31:0]              csr_pc,
    input  logic [NUM_THREADS-1:0]   csr_tmask,
    input  logic                     csr_wb,
    input  logic [NR_BITS-1:0]       csr_rd,
    input  logic [NUM_THREADS*32-1:0] csr_data,

    input  logic                     fpu_valid,
    output logic                     fpu_ready,
    input  logic [NW_BITS-1:0]       fpu_wid,
    input  logic [31:0]              fpu_pc,
    input  logic [NUM_THREADS-1:0]   fpu_tmask,
    input  logic                     fpu_wb,
    input  logic [NR_BITS-1:0]       fpu_rd,
    input  logic [NUM_THREADS*32-1:0] fpu_data,

    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [NW_BITS-1:0]       st_wid,
    input  logic [31:0]              st_pc,
    input  logic [NUM_THREADS-1:0]   st_tmask,
    input  logic                     st_wb,
    input  logic [NR_BITS-1:0]       st_rd,
    input  logic [NUM_THREADS*32-1:0] st_data,

    input  logic                     gpu_valid,
    output logic                     gpu_ready,
    input  logic [NW_BITS-1:0]       gpu_wid,
    input  logic [31:0]              gpu_pc,
    input  logic [NUM_THREADS-1:0]   gpu_tmask,
    input  logic                     gpu_wb,
    input  logic [NR_BITS-1:0]       gpu_rd,
    input  logic [NUM_THREADS*32-1:0] gpu_data,

    output logic                     wb_valid,
    output logic [NW_BITS-1:0]       wb_wid,
    output logic [31:0]              wb_pc,
    output logic [NUM_THREADS-1:0]   wb_tmask,
    output logic [NR_BITS-1:0]       wb_rd,
    output logic [NUM_THREADS*32-1:0] wb_data,

    output logic                     cmt_valid,
    output logic [CMTW-1:0]          cmt_size
);

    function automatic logic [CMTW-1:0] popcount(input logic [3*NUM_THREADS-1:0] v);
        logic [CMTW-1:0] c;
        c = '0;
        for (int i = 0; i < 3*NUM_THREADS; i++)
            c = c + CMTW'(v[i]);
        return c;
    endfunction

    logic req_ld_p0, req_fpu_p0, req_csr_p0, req_alu_p0, any_req_p0;
    logic alu_fire_p0, ld_fire_p0, csr_fire_p0, fpu_fire_p0, st_fire_p0, gpu_fire_p0;
    logic [NUM_THREADS-1:0]    g1_p0, g2_p0, g3_p0;
    logic [CMTW-1:0]           cnt_p0;
    logic [NW_BITS-1:0]        sel_wid_p0;
    logic [31:0]               sel_pc_p0;
    logic [NUM_THREADS-1:0]    sel_tmask_p0;
    logic [NR_BITS-1:0]        sel_rd_p0;
    logic [NUM_THREADS*32-1:0] sel_data_p0;

    logic                      wb_valid_p1, cmt_valid_p1;
    logic [NW_BITS-1:0]        wb_wid_p1;
    logic [31:0]               wb_pc_p1;
    logic [NUM_THREADS-1:0]    wb_tmask_p1;
    logic [NR_BITS-1:0]        wb_rd_p1;
    logic [NUM_THREADS*32-1:0] wb_data_p1;
    logic [CMTW-1:0]           cmt_size_p1;

    // Stage p0: requests, readies, grant select and commit count
    assign req_ld_p0  = ld_valid  & ld_wb;
    assign req_fpu_p0 = fpu_valid & fpu_wb;
    assign req_csr_p0 = csr_valid & csr_wb;
    assign req_alu_p0 = alu_valid & alu_wb;
    assign any_req_p0 = req_ld_p0 | req_fpu_p0 | req_csr_p0 | req_alu_p0;

    // Readies depend only on valid/wb so that no combinational loop through ready exists.
    assign ld_ready  = 1'b1;
    assign fpu_ready = !req_ld_p0 | !fpu_wb;
    assign csr_ready = !(req_ld_p0 | req_fpu_p0) | !csr_wb;
    assign alu_ready = !(req_ld_p0 | req_fpu_p0 | req_csr_p0) | !alu_wb;
    assign st_ready  = 1'b1;
    assign gpu_ready = 1'b1;

    assign alu_fire_p0 = alu_valid & alu_ready;
    assign ld_fire_p0  = ld_valid  & ld_ready;
    assign csr_fire_p0 = csr_valid & csr_ready;
    assign fpu_fire_p0 = fpu_valid & fpu_ready;
    assign st_fire_p0  = st_valid  & st_ready;
    assign gpu_fire_p0 = gpu_valid & gpu_ready;

    always_comb begin
        sel_wid_p0   = alu_wid;
        sel_pc_p0    = alu_pc;
        sel_tmask_p0 = alu_tmask;
        sel_rd_p0    = alu_rd;
        sel_data_p0  = alu_data;
        // Later assignments override earlier ones, so ld ends up highest priority.
        if (req_csr_p0) begin
            sel_wid_p0 = csr_wid; sel_pc_p0 = csr_pc; sel_tmask_p0 = csr_tmask;
            sel_rd_p0  = csr_rd;  sel_data_p0 = csr_data;
        end
        if (req_fpu_p0) begin
            sel_wid_p0 = fpu_wid; sel_pc_p0 = fpu_pc; sel_tmask_p0 = fpu_tmask;
            sel_rd_p0  = fpu_rd;  sel_data_p0 = fpu_data;
        end
        if (req_ld_p0) begin
            sel_wid_p0 = ld_wid;  sel_pc_p0 = ld_pc;  sel_tmask_p0 = ld_tmask;
            sel_rd_p0  = ld_rd;   sel_data_p0 = ld_data;
        end
    end

    // Only one group-1 commit is counted per cycle, first in alu, ld, csr, fpu order.
    always_comb begin
        g1_p0 = '0;
        if (alu_fire_p0)      g1_p0 = alu_tmask;
        else if (ld_fire_p0)  g1_p0 = ld_tmask;
        else if (csr_fire_p0) g1_p0 = csr_tmask;
        else if (fpu_fire_p0) g1_p0 = fpu_tmask;
    end

    assign g2_p0  = st_fire_p0  ? st_tmask  : '0;
    assign g3_p0  = gpu_fire_p0 ? gpu_tmask : '0;
    assign cnt_p0 = popcount({g3_p0, g2_p0, g1_p0});

    // Stage p1: registered writeback port and commit count
    always_ff @(posedge clk) begin
        if (!reset) begin
            wb_valid_p1  <= 1'b0;
            cmt_valid_p1 <= 1'b0;
            cmt_size_p1  <= '0;
            wb_wid_p1    <= '0;
            wb_pc_p1     <= '0;
            wb_tmask_p1  <= '0;
            wb_rd_p1     <= '0;
            wb_data_p1   <= '0;
        end else begin
            wb_valid_p1  <= any_req_p0;
            cmt_valid_p1 <= alu_fire_p0 | ld_fire_p0 | csr_fire_p0
                          | fpu_fire_p0 | st_fire_p0 | gpu_fire_p0;
            cmt_size_p1  <= cnt_p0;
            if (any_req_p0) begin
                wb_wid_p1   <= sel_wid_p0;
                wb_pc_p1    <= sel_pc_p0;
                wb_tmask_p1 <= sel_tmask_p0;
                wb_rd_p1    <= sel_rd_p0;
                wb_data_p1  <= sel_data_p0;
            end
        end
    end

    assign wb_valid  = wb_valid_p1;
    assign wb_wid    = wb_wid_p1;
    assign wb_pc     = wb_pc_p1;
    assign wb_tmask  = wb_tmask_p1;
    assign wb_rd     = wb_rd_p1;
    assign wb_data   = wb_data_p1;
    assign cmt_valid = cmt_valid_p1;
    assign cmt_size  = cmt_size_p1;

    // Store/GPU writeback fields and the debug-only identifiers have no datapath use.
    logic unused_sig;
    assign unused_sig = ^{st_wb, st_rd, st_data, st_wid, st_pc,
                          gpu_wb, gpu_rd, gpu_data, gpu_wid, gpu_pc, 32'(CORE_ID)};

`ifdef DBG_PRINT_PIPELINE
    always @(posedge clk) begin
        if (alu_fire_p0) $display("%t: core%0d-commit: wid=%0d, PC=0x%0h, ex=ALU, tmask=%b, wb=%0d, rd=%0d, data=0x%0h", $time, CORE_ID, alu_wid, alu_pc, alu_tmask, alu_wb, alu_rd, alu_data);
        if (ld_fire_p0)  $display("%t: core%0d-commit: wid=%0d, PC=0x%0h, ex=LSU, tmask=%b, wb=%0d, rd=%0d, data=0x%0h", $time, CORE_ID, ld_wid, ld_pc, ld_tmask, ld_wb, ld_rd, ld_data);
        if (csr_fire_p0) $display("%t: core%0d-commit: wid=%0d, PC=0x%0h, ex=CSR, tmask=%b, wb=%0d, rd=%0d, data=0x%0h", $time, CORE_ID, csr_wid, csr_pc, csr_tmask, csr_wb, csr_rd, csr_data);
        if (fpu_fire_p0) $display("%t: core%0d-commit: wid=%0d, PC=0x%0h, ex=FPU, tmask=%b, wb=%0d, rd=%0d, data=0x%0h", $time, CORE_ID, fpu_wid, fpu_pc, fpu_tmask, fpu_wb, fpu_rd, fpu_data);
        if (st_fire_p0)  $display("%t: core%0d-commit: wid=%0d, PC=0x%0h, ex=STORE, tmask=%b, wb=%0d, rd=%0d, data=0x%0h", $time, CORE_ID, st_wid, st_pc, st_tmask, st_wb, st_rd, st_data);
        if (gpu_fire_p0) $display("%t: core%0d-commit: wid=%0d, PC=0x%0h, ex=GPU, tmask=%b, wb=%0d, rd=%0d, data=0x%0h", $time, CORE_ID, gpu_wid, gpu_pc, gpu_tmask, gpu_wb, gpu_rd, gpu_data);
    end
`endif

endmodule

// File: tb/tb_commit_stage.sv
// Directed testbench for commit_stage: writeback arbitration, ready rules and commit counting.
module tb_commit_stage;
    localparam int NT = 4;
    localparam int NW = 2;
    localparam int NR = 5;
    localparam int DW = NT*32;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset;

    logic          alu_valid, alu_ready, alu_wb;
    logic [NW-1:0] alu_wid;
    logic [31:0]   alu_pc;
    logic [NT-1:0] alu_tmask;
    logic [NR-1:0] alu_rd;
    logic [DW-1:0] alu_data;

    logic          ld_valid, ld_ready, ld_wb;
    logic [NW-1:0] ld_wid;
    logic [31:0]   ld_pc;
    logic [NT-1:0] ld_tmask;
    logic [NR-1:0] ld_rd;
    logic [DW-1:0] ld_data;

    logic          csr_valid, csr_ready, csr_wb;
    logic [NW-1:0] csr_wid;
    logic [31:0]   csr_pc;
    logic [NT-1:0] csr_tmask;
    logic [NR-1:0] csr_rd;
    logic [DW-1:0] csr_data;

    logic          fpu_valid, fpu_ready, fpu_wb;
    logic [NW-1:0] fpu_wid;
    logic [31:0]   fpu_pc;
    logic [NT-1:0] fpu_tmask;
    logic [NR-1:0] fpu_rd;
    logic [DW-1:0] fpu_data;

    logic          st_valid, st_ready, st_wb;
    logic [NW-1:0] st_wid;
    logic [31:0]   st_pc;
    logic [NT-1:0] st_tmask;
    logic [NR-1:0] st_rd;
    logic [DW-1:0] st_data;

    logic          gpu_valid, gpu_ready, gpu_wb;
    logic [NW-1:0] gpu_wid;
    logic [31:0]   gpu_pc;
    logic [NT-1:0] gpu_tmask;
    logic [NR-1:0] gpu_rd;
    logic [DW-1:0] gpu_data;

    logic          wb_valid;
    logic [NW-1:0] wb_wid;
    logic [31:0]   wb_pc;
    logic [NT-1:0] wb_tmask;
    logic [NR-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          cmt_valid;
    logic [CW-1:0] cmt_size;

    int checks = 0;
    int failures = 0;

    localparam logic [DW-1:0] D_ALU1 = 128'h00000004_00000003_00000002_00000001;
    localparam logic [DW-1:0] D_FPU  = 128'h22222222_22220002_22220001_22220000;
    localparam logic [DW-1:0] D_LD   = 128'h11110003_11110002_11110001_11110000;
    localparam logic [DW-1:0] D_ALU2 = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;

    commit_stage #(.CORE_ID(0), .NUM_THREADS(NT), .NUM_WARPS(4), .NR_BITS(NR)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_wid(alu_wid), .alu_pc(alu_pc),
        .alu_tmask(alu_tmask), .alu_wb(alu_wb), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_wid(ld_wid), .ld_pc(ld_pc),
        .ld_tmask(ld_tmask), .ld_wb(ld_wb), .ld_rd(ld_rd), .ld_data(ld_data),
        .csr_valid(csr_valid), .csr_ready(csr_ready), .csr_wid(csr_wid), .csr_pc(csr_pc),
        .csr_tmask(csr_tmask), .csr_wb(csr_wb), .csr_rd(csr_rd), .csr_data(csr_data),
        .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .fpu_wid(fpu_wid), .fpu_pc(fpu_pc),
        .fpu_tmask(fpu_tmask), .fpu_wb(fpu_wb), .fpu_rd(fpu_rd), .fpu_data(fpu_data),
        .st_valid(st_valid), .st_ready(st_ready), .st_wid(st_wid), .st_pc(st_pc),
        .st_tmask(st_tmask), .st_wb(st_wb), .st_rd(st_rd), .st_data(st_data),
        .gpu_valid(gpu_valid), .gpu_ready(gpu_ready), .gpu_wid(gpu_wid), .gpu_pc(gpu_pc),
        .gpu_tmask(gpu_tmask), .gpu_wb(gpu_wb), .gpu_rd(gpu_rd), .gpu_data(gpu_data),
        .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_pc(wb_pc), .wb_tmask(wb_tmask),
        .wb_rd(wb_rd), .wb_data(wb_data), .cmt_valid(cmt_valid), .cmt_size(cmt_size)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        alu_valid = 0; alu_wid = 0; alu_pc = 0; alu_tmask = 0; alu_wb = 0; alu_rd = 0; alu_data = 0;
        ld_valid  = 0; ld_wid  = 0; ld_pc  = 0; ld_tmask  = 0; ld_wb  = 0; ld_rd  = 0; ld_data  = 0;
        csr_valid = 0; csr_wid = 0; csr_pc = 0; csr_tmask = 0; csr_wb = 0; csr_rd = 0; csr_data = 0;
        fpu_valid = 0; fpu_wid = 0; fpu_pc = 0; fpu_tmask = 0; fpu_wb = 0; fpu_rd = 0; fpu_data = 0;
        st_valid  = 0; st_wid  = 0; st_pc  = 0; st_tmask  = 0; st_wb  = 0; st_rd  = 0; st_data  = 0;
        gpu_valid = 0; gpu_wid = 0; gpu_pc = 0; gpu_tmask = 0; gpu_wb = 0; gpu_rd = 0; gpu_data = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        ld_valid = 1; ld_wb = 1; ld_rd = 9; ld_tmask = 4'b0011; ld_data = D_LD;
        fpu_valid = 1; fpu_wb = 1; fpu_rd = 2; fpu_tmask = 4'b1111;
        csr_valid = 1; csr_wb = 1; csr_rd = 3; csr_tmask = 4'b1111;
        alu_valid = 1; alu_wb = 1; alu_rd = 4; alu_tmask = 4'b1111;
        st_valid = 1; st_tmask = 4'b1111;
        gpu_valid = 1; gpu_tmask = 4'b0001;
        @(posedge clk); #1;
        checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL rst_ld_ready got=%b exp=1", ld_ready); end
        checks++; if (alu_ready !== 1'b0) begin failures++; $display("FAIL rst_alu_ready got=%b exp=0", alu_ready); end
        checks++; if (st_ready !== 1'b1 || gpu_ready !== 1'b1) begin failures++; $display("FAIL rst_st_gpu_ready got=%b%b exp=11", st_ready, gpu_ready); end
        @(posedge clk); #1;
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL rst_wb_valid got=%b exp=0", wb_valid); end
        checks++; if (cmt_valid !== 1'b0) begin failures++; $display("FAIL rst_cmt_valid got=%b exp=0", cmt_valid); end
        checks++; if (cmt_size !== 4'd0) begin failures++; $display("FAIL rst_cmt_size got=%0d exp=0", cmt_size); end
        checks++; if (wb_rd !== 5'd0 || wb_data !== '0 || wb_tmask !== 4'd0) begin failures++; $display("FAIL rst_wb_fields got rd=%0d tmask=%b data=%h exp zero", wb_rd, wb_tmask, wb_data); end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL post_rst_wb_valid got=%b exp=1", wb_valid); end
        checks++; if (wb_rd !== 5'd9) begin failures++; $display("FAIL post_rst_wb_rd got=%0d exp=9", wb_rd); end
        checks++; if (cmt_valid !== 1'b1 || cmt_size !== 4'd7) begin failures++; $display("FAIL post_rst_cmt got v=%b size=%0d exp v=1 size=7", cmt_valid, cmt_size); end
    endtask

    task automatic test_single_alu();
        clear_inputs();
        alu_valid = 1; alu_wb = 1; alu_rd = 7; alu_tmask = 4'b1011; alu_data = D_ALU1;
        alu_wid = 2'd2; alu_pc = 32'h0000_0100;
        #1;
        checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL alu_ready got=%b exp=1", alu_ready); end
        @(posedge clk); #1;
        checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL alu_wb_valid got=%b exp=1", wb_valid); end
        checks++; if (wb_rd !== 5'd7) begin failures++; $display("FAIL alu_wb_rd got=%0d exp=7", wb_rd); end
        checks++; if (wb_tmask !== 4'b1011) begin failures++; $display("FAIL alu_wb_tmask got=%b exp=1011", wb_tmask); end
        checks++; if (wb_data !== D_ALU1) begin failures++; $display("FAIL alu_wb_data got=%h exp=%h", wb_data, D_ALU1); end
        checks++; if (wb_wid !== 2'd2 || wb_pc !== 32'h100) begin failures++; $display("FAIL alu_wb_wid_pc got wid=%0d pc=%h exp wid=2 pc=100", wb_wid, wb_pc); end
        checks++; if (cmt_valid !== 1'b1 || cmt_size !== 4'd3) begin failures++; $display("FAIL alu_cmt got v=%b size=%0d exp v=1 size=3", cmt_valid, cmt_size); end
    endtask

    task automatic test_priority();
        clear_inputs();
        ld_valid  = 1; ld_wb  = 1; ld_rd  = 1; ld_tmask  = 4'b0001; ld_data = D_LD;
        fpu_valid = 1; fpu_wb = 1; fpu_rd = 2; fpu_tmask = 4'b0011; fpu_data = D_FPU;
        csr_valid = 1; csr_wb = 1; csr_rd = 3; csr_tmask = 4'b0111;
        alu_valid = 1; alu_wb = 1; alu_rd = 4; alu_tmask = 4'b1111;
        #1;
        checks++; if ({ld_ready, fpu_ready, csr_ready, alu_ready} !== 4'b1000) begin failures++; $display("FAIL prio_ready0 got=%b exp=1000", {ld_ready, fpu_ready, csr_ready, alu_ready}); end
        @(posedge clk); #1;
        checks++; if (wb_rd !== 5'd1 || cmt_size !== 4'd1) begin failures++; $display("FAIL prio_ld got rd=%0d size=%0d exp rd=1 size=1", wb_rd, cmt_size); end
        ld_valid = 0;
        #1;
        checks++; if ({fpu_ready, csr_ready, alu_ready} !== 3'b100) begin failures++; $display("FAIL prio_ready1 got=%b exp=100", {fpu_ready, csr_ready, alu_ready}); end
        @(posedge clk); #1;
        checks++; if (wb_rd !== 5'd2 || cmt_size !== 4'd2) begin failures++; $display("FAIL prio_fpu got rd=%0d size=%0d exp rd=2 size=2", wb_rd, cmt_size); end
        checks++; if (wb_data !== D_FPU) begin failures++; $display("FAIL prio_fpu_data got=%h exp=%h", wb_data, D_FPU); end
        fpu_valid = 0;
        @(posedge clk); #1;
        checks++; if (wb_rd !== 5'd3 || cmt_size !== 4'd3) begin failures++; $display("FAIL prio_csr got rd=%0d size=%0d exp rd=3 size=3", wb_rd, cmt_size); end
        csr_valid = 0;
        @(posedge clk); #1;
        checks++; if (wb_rd !== 5'd4 || cmt_size !== 4'd4 || wb_valid !== 1'b1) begin failures++; $display("FAIL prio_alu got rd=%0d size=%0d v=%b exp rd=4 size=4 v=1", wb_rd, cmt_size, wb_valid); end
    endtask

    task automatic test_nowb_bypass();
        clear_inputs();
        ld_valid  = 1; ld_wb  = 1; ld_rd  = 5;  ld_tmask  = 4'b0110; ld_data = D_LD;
        alu_valid = 1; alu_wb = 0; alu_rd = 20; alu_tmask = 4'b1111;
        #1;
        checks++; if (ld_ready !== 1'b1 || alu_ready !== 1'b1) begin failures++; $display("FAIL nowb_ready got ld=%b alu=%b exp 1 1", ld_ready, alu_ready); end
        @(posedge clk); #1;
        checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_tmask !== 4'b0110) begin failures++; $display("FAIL nowb_wb got v=%b rd=%0d tmask=%b exp v=1 rd=5 tmask=0110", wb_valid, wb_rd, wb_tmask); end
        checks++; if (cmt_size !== 4'd4) begin failures++; $display("FAIL nowb_cmt_size got=%0d exp=4", cmt_size); end
    endtask

    task automatic test_st_gpu();
        clear_inputs();
        st_valid  = 1; st_tmask  = 4'b1111; st_wb = 1; st_rd = 31; st_data = '1;
        gpu_valid = 1; gpu_tmask = 4'b0011; gpu_wb = 1; gpu_rd = 30;
        alu_valid = 1; alu_wb = 1; alu_rd = 12; alu_tmask = 4'b0001; alu_data = D_ALU2;
        #1;
        checks++; if ({st_ready, gpu_ready, alu_ready} !== 3'b111) begin failures++; $display("FAIL stgpu_ready got=%b exp=111", {st_ready, gpu_ready, alu_ready}); end
        @(posedge clk); #1;
        checks++; if (cmt_size !== 4'd7 || cmt_valid !== 1'b1) begin failures++; $display("FAIL stgpu_cmt got v=%b size=%0d exp v=1 size=7", cmt_valid, cmt_size); end
        checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd12) begin failures++; $display("FAIL stgpu_wb got v=%b rd=%0d exp v=1 rd=12", wb_valid, wb_rd); end
    endtask

    task automatic test_idle();
        clear_inputs();
        @(posedge clk); #1;
        checks++; if (wb_valid !== 1'b0 || cmt_valid !== 1'b0 || cmt_size !== 4'd0) begin failures++; $display("FAIL idle_ctrl got wbv=%b cmtv=%b size=%0d exp 0 0 0", wb_valid, cmt_valid, cmt_size); end
        checks++; if (wb_rd !== 5'd12 || wb_tmask !== 4'b0001 || wb_data !== D_ALU2) begin failures++; $display("FAIL idle_hold got rd=%0d tmask=%b data=%h exp rd=12 tmask=0001 data=%h", wb_rd, wb_tmask, wb_data, D_ALU2); end
    endtask

    task automatic test_max_count();
        clear_inputs();
        st_valid  = 1; st_tmask  = 4'b1111;
        gpu_valid = 1; gpu_tmask = 4'b1111;
        csr_valid = 1; csr_wb = 0; csr_tmask = 4'b1111; csr_rd = 6;
        fpu_valid = 1; fpu_wb = 0; fpu_tmask = 4'b1111; fpu_rd = 8;
        #1;
        checks++; if (csr_ready !== 1'b1 || fpu_ready !== 1'b1) begin failures++; $display("FAIL max_ready got csr=%b fpu=%b exp 1 1", csr_ready, fpu_ready); end
        @(posedge clk); #1;
        checks++; if (cmt_size !== 4'd12 || cmt_valid !== 1'b1) begin failures++; $display("FAIL max_cmt got v=%b size=%0d exp v=1 size=12", cmt_valid, cmt_size); end
        checks++; if (wb_valid !== 1'b0 || wb_rd !== 5'd12) begin failures++; $display("FAIL max_no_wb got v=%b rd=%0d exp v=0 rd=12", wb_valid, wb_rd); end
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        alu_valid = 1; alu_wb = 1; alu_rd = 10; alu_tmask = 4'b0011;
        @(posedge clk); #1;
        checks++; if (wb_rd !== 5'd10 || cmt_size !== 4'd2) begin failures++; $display("FAIL b2b_first got rd=%0d size=%0d exp rd=10 size=2", wb_rd, cmt_size); end
        alu_rd = 11; alu_tmask = 4'b1110;
        @(posedge clk); #1;
        checks++; if (wb_rd !== 5'd11 || wb_tmask !== 4'b1110 || cmt_size !== 4'd3) begin failures++; $display("FAIL b2b_second got rd=%0d tmask=%b size=%0d exp rd=11 tmask=1110 size=3", wb_rd, wb_tmask, cmt_size); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_priority();
        test_nowb_bypass();
        test_st_gpu();
        test_idle();
        test_max_count();
        test_back_to_back();
        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
